hbmc_axi_bresp_gen: RTL and testbench

- Read-side consumer of the AXI ID FIFO: pops transaction IDs stored on AW acceptance and issues the matching AXI4 write responses (B channel) in order.
- Each response is issued once the memory engine reports the corresponding write burst complete.
- Sits between the ID FIFO read port, the HyperBus write-completion strobe and the slave AXI B channel.
- Counts completions that arrive before their response can be issued, so no completion is lost while the B channel is back-pressured.

---
 rtl/hbmc_axi_pkg.sv | 17 +
 rtl/hbmc_sat_counter.sv | 44 ++++
 rtl/hbmc_axi_bresp_gen.sv | 128 ++++++++++++
 tb/tb_hbmc_axi_bresp_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbmc_axi_pkg.sv
// Shared definitions for the HyperBus controller AXI slave side:
// AXI response codes and the B-response generator state encoding.
package hbmc_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2,
    RESP = 2'd3
  } bresp_state_t;

endpackage

// File: rtl/hbmc_sat_counter.sv
// Up/down counter that saturates at MAX_VAL and latches a sticky overflow
// flag when an increment is requested at saturation without a decrement.
// A simultaneous increment and decrement cancel out.
module hbmc_sat_counter #(
  parameter int MAX_VAL = 15,
  parameter int CNT_W   = $clog2(MAX_VAL + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  // Count completions in and responses out; drop and flag increments at the ceiling.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (i_inc && !i_dec) begin
        if (r_cnt == MAX_CNT) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (!i_inc && i_dec) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/hbmc_axi_bresp_gen.sv
// AXI4 write-response generator. Pops IDs from the AW-side ID FIFO and
// issues one B response per completed HyperBus write burst, in FIFO order.
// Completions arriving while B is back-pressured are counted so none are lost.
// Optional macro HBMC_BRESP_STATS_EN adds a free-running count of B handshakes
// on resp_count; without it resp_count is tied to zero.
module hbmc_axi_bresp_gen
  import hbmc_axi_pkg::*;
#(
  parameter int AXI_ID_WIDTH = 8,
  parameter int MAX_PENDING  = 15
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             wr_done,
  input  logic [AXI_ID_WIDTH-1:0]          fifo_rd_dout,
  output logic                             fifo_rd_ena,
  input  logic                             fifo_rd_empty,
  output logic [AXI_ID_WIDTH-1:0]          s_axi_bid,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  output logic [$clog2(MAX_PENDING+1)-1:0] pend_cnt,
  output logic                             err_ovf,
  output logic [31:0]                      resp_count
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  bresp_state_t            r_state;
  logic                    r_rd_ena;
  logic                    r_bvalid;
  logic [AXI_ID_WIDTH-1:0] r_bid;
  logic [1:0]              r_bresp;

  logic [CNT_W-1:0]        w_pend_cnt;
  logic                    w_pend_ovf;
  logic                    w_load;
  logic                    w_b_hs;
  logic                    w_can_pop;

  assign w_load    = (r_state == LOAD);
  assign w_b_hs    = r_bvalid && s_axi_bready;
  // A pop needs both a finished burst and an ID to pair it with.
  assign w_can_pop = (w_pend_cnt != '0) && !fifo_rd_empty;

  hbmc_sat_counter #(
    .MAX_VAL (MAX_PENDING),
    .CNT_W   (CNT_W)
  ) u_pend_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (wr_done),
    .i_dec (w_load),
    .o_cnt (w_pend_cnt),
    .o_ovf (w_pend_ovf)
  );

  // Response sequencer: IDLE -> POP -> LOAD -> RESP, all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_rd_ena <= 1'b0;
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= AXI_RESP_OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_can_pop) begin
            r_state  <= POP;
            r_rd_ena <= 1'b1;
          end
        end
        POP: begin
          r_state  <= LOAD;
          r_rd_ena <= 1'b0;
        end
        LOAD: begin
          r_bid    <= fifo_rd_dout;
          r_bresp  <= AXI_RESP_OKAY;
          r_bvalid <= 1'b1;
          r_state  <= RESP;
        end
        RESP: begin
          if (w_b_hs) begin
            r_bvalid <= 1'b0;
            if (w_can_pop) begin
              r_state  <= POP;
              r_rd_ena <= 1'b1;
            end else begin
              r_state  <= IDLE;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rd_ena <= 1'b0;
          r_bvalid <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_ena  = r_rd_ena;
  assign s_axi_bvalid = r_bvalid;
  assign s_axi_bid    = r_bid;
  assign s_axi_bresp  = r_bresp;
  assign pend_cnt     = w_pend_cnt;
  assign err_ovf      = w_pend_ovf;

`ifdef HBMC_BRESP_STATS_EN
  logic [31:0] r_resp_count;

  // Count every accepted B response; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_count <= '0;
    end else if (w_b_hs) begin
      r_resp_count <= r_resp_count + 32'd1;
    end
  end

  assign resp_count = r_resp_count;
`else
  assign resp_count = '0;
`endif

endmodule

// File: tb/tb_hbmc_axi_bresp_gen.sv
// Directed bench for hbmc_axi_bresp_gen with a behavioural ID FIFO and an
// in-order scoreboard of expected B-channel IDs.
module tb_hbmc_axi_bresp_gen;

`ifdef HBMC_BRESP_STATS_EN
  localparam int EXP_RC_AFTER3 = 3;
`else
  localparam int EXP_RC_AFTER3 = 0;
`endif

  logic        clk;
  logic        rstn;
  logic        wr_done;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_rd_ena;
  logic        fifo_empty;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  pend_cnt;
  logic        err_ovf;
  logic [31:0] resp_count;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int bad_pop   = 0;

  logic [7:0] fifo_mem [0:63];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;
  logic [7:0] exp_q [$];

  hbmc_axi_bresp_gen #(
    .AXI_ID_WIDTH (8),
    .MAX_PENDING  (15)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .wr_done       (wr_done),
    .fifo_rd_dout  (fifo_dout),
    .fifo_rd_ena   (fifo_rd_ena),
    .fifo_rd_empty (fifo_empty),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .pend_cnt      (pend_cnt),
    .err_ovf       (err_ovf),
    .resp_count    (resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: data appears the cycle after the pop strobe.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_ena && !fifo_empty) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
    end
  end

  // Any pop strobe while the FIFO is empty is an error.
  always @(negedge clk) begin
    if (rstn && fifo_rd_ena && fifo_empty) bad_pop <= bad_pop + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_id(input logic [7:0] id);
    fifo_mem[wr_ptr] = id;
    wr_ptr = wr_ptr + 6'd1;
    exp_q.push_back(id);
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      wr_done = 1'b1;
      @(negedge clk);
    end
    wr_done = 1'b0;
  endtask

  // Wait (bounded) for a B handshake, compare against the scoreboard head,
  // then step past the handshake edge.
  task automatic expect_resp(input string tag, output int hs_cyc);
    bit got = 0;
    logic [7:0] e;
    hs_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (bvalid && bready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      hs_cyc = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_bid"}, {24'd0, bid}, {24'd0, e});
      end else begin
        chk({tag, "_unexpected"}, {24'd0, bid}, 32'hFFFF_FFFF);
      end
      chk({tag, "_bresp"}, {30'd0, bresp}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1, h2, h3, hx;
    bit seen;
    rstn    = 1'b0;
    wr_done = 1'b0;
    bready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bvalid", {31'd0, bvalid}, 0);
    chk("rst_rd_ena", {31'd0, fifo_rd_ena}, 0);
    chk("rst_bid", {24'd0, bid}, 0);
    chk("rst_bresp", {30'd0, bresp}, 0);
    chk("rst_pend", {28'd0, pend_cnt}, 0);
    chk("rst_ovf", {31'd0, err_ovf}, 0);
    chk("rst_resp_count", resp_count, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single write: latency of pop strobe and response
    bready = 1'b1;
    push_id(8'h5A);
    @(negedge clk);
    wr_done = 1'b1;                         // cycle 0
    @(negedge clk); wr_done = 1'b0;         // cycle 1
    chk("t1_ena_c1", {31'd0, fifo_rd_ena}, 0);
    chk("t1_pend_c1", {28'd0, pend_cnt}, 1);
    @(negedge clk);                         // cycle 2
    chk("t1_ena_c2", {31'd0, fifo_rd_ena}, 1);
    @(negedge clk);                         // cycle 3
    chk("t1_ena_c3", {31'd0, fifo_rd_ena}, 0);
    chk("t1_bvalid_c3", {31'd0, bvalid}, 0);
    @(negedge clk);                         // cycle 4
    chk("t1_bvalid_c4", {31'd0, bvalid}, 1);
    expect_resp("t1", hx);
    chk("t1_pend_end", {28'd0, pend_cnt}, 0);
    chk("t1_bvalid_end", {31'd0, bvalid}, 0);

    // Back-pressure and in-order back-to-back release
    bready = 1'b0;
    push_id(8'h01); push_id(8'h02); push_id(8'h03);
    @(negedge clk);
    strobe(3);
    repeat (20) @(negedge clk);
    chk("t2_bvalid_held", {31'd0, bvalid}, 1);
    chk("t2_bid_held", {24'd0, bid}, 32'h01);
    chk("t2_pend_held", {28'd0, pend_cnt}, 2);
    bready = 1'b1;
    expect_resp("t2a", h1);
    expect_resp("t2b", h2);
    expect_resp("t2c", h3);
    chk("t2_gap_ab", h2 - h1, 3);
    chk("t2_gap_bc", h3 - h2, 3);

    // Completion before its ID is available
    @(negedge clk);
    strobe(1);
    repeat (9) @(negedge clk);
    chk("t3_pend_wait", {28'd0, pend_cnt}, 1);
    chk("t3_bvalid_wait", {31'd0, bvalid}, 0);
    chk("t3_ena_wait", {31'd0, fifo_rd_ena}, 0);
    push_id(8'h7F);
    expect_resp("t3", hx);

    // Saturation of the pending counter
    bready = 1'b0;
    strobe(15);
    chk("t4_pend_15", {28'd0, pend_cnt}, 15);
    chk("t4_ovf_before", {31'd0, err_ovf}, 0);
    strobe(1);
    chk("t4_pend_sat", {28'd0, pend_cnt}, 15);
    chk("t4_ovf_after", {31'd0, err_ovf}, 1);
    for (int i = 0; i < 15; i++) push_id(8'h10 + 8'(i));
    bready = 1'b1;
    for (int i = 0; i < 15; i++) expect_resp($sformatf("t4_r%0d", i), hx);
    chk("t4_pend_drained", {28'd0, pend_cnt}, 0);
    repeat (5) @(negedge clk);
    chk("t4_no_extra", {31'd0, bvalid}, 0);

    // wr_done coincident with LOAD
    push_id(8'hA1); push_id(8'hA2);
    @(negedge clk);
    wr_done = 1'b1;                         // cycle 0
    @(negedge clk); wr_done = 1'b0;         // cycle 1
    @(negedge clk);                         // cycle 2
    chk("t5_ena_c2", {31'd0, fifo_rd_ena}, 1);
    @(negedge clk);                         // cycle 3 = LOAD
    wr_done = 1'b1;
    chk("t5_pend_c3", {28'd0, pend_cnt}, 1);
    @(negedge clk); wr_done = 1'b0;         // cycle 4
    chk("t5_pend_c4", {28'd0, pend_cnt}, 1);
    chk("t5_bvalid_c4", {31'd0, bvalid}, 1);
    expect_resp("t5a", hx);
    expect_resp("t5b", hx);
    chk("t5_pend_end", {28'd0, pend_cnt}, 0);

    // Asynchronous reset in the middle of a response
    chk("t6_ovf_sticky", {31'd0, err_ovf}, 1);
    bready = 1'b0;
    push_id(8'hB1);
    @(negedge clk);
    strobe(1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("t6_bvalid_pre", {31'd0, seen}, 1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_bvalid_rst", {31'd0, bvalid}, 0);
    chk("t6_pend_rst", {28'd0, pend_cnt}, 0);
    chk("t6_ovf_rst", {31'd0, err_ovf}, 0);
    chk("t6_rc_rst", resp_count, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    push_id(8'hC1); push_id(8'hC2); push_id(8'hC3);
    bready = 1'b1;
    @(negedge clk);
    strobe(3);
    expect_resp("t6a", hx);
    expect_resp("t6b", hx);
    expect_resp("t6c", hx);
    chk("t6_resp_count", resp_count, EXP_RC_AFTER3);

    // Global end-of-run checks
    repeat (3) @(negedge clk);
    chk("end_bad_pop", bad_pop, 0);
    chk("end_scoreboard", exp_q.size(), 0);
    chk("end_pend", {28'd0, pend_cnt}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
